div_iter: RTL
=============

# div_iter

Parametrised multi-cycle integer divider for the MIPS core's multiply/divide unit, replacing the fixed 32-bit divider. It performs radix-2 restoring division over `WIDTH` iterations, in signed or unsigned mode, and follows MIPS semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend. Operands and mode are captured on a valid/ready handshake, and results are held until consumed. A `cancel` input lets the pipeline flush an in-flight divide on an exception.

## Interface
- `WIDTH`, default 32: operand and result width; any integer ≥ 4.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  high only in IDLE.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- `a`  in  WIDTH  dividend; sampled at accept.
- `b`  in  WIDTH  divisor; sampled at accept.
- `cancel`  in  1  abort the current operation and discard the result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_zero`  out  1  result came from b == 0.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE → BUSY:** on `in_valid && in_ready` (the accept edge). Latch the magnitudes |a| and |b|; negate only when `sign && msb`. Latch the quotient sign `a[W-1]^b[W-1]`, the remainder sign `a[W-1]`, the zero flag, and `sign`. Clear the counter.
- **BUSY:** each edge, shift the {rem, quo} pair left by 1. If rem ≥ |b|, subtract |b| and set the quotient LSB. The counter increments. Subtraction and compare use WIDTH+1 bits, so |a| = 2^(W-1) is exact.
- **BUSY → DONE:** on the edge that completes iteration WIDTH. The same edge applies the two's-complement sign correction and loads `quotient` and `remainder`.
- **DONE → IDLE:** on `out_valid && out_ready`. Outputs stay stable in DONE regardless of `a`, `b`, `sign`.
- **Overflow:** signed MIN / −1 gives quotient = MIN and remainder = 0, with no flag.
- **Divide by zero without the macro:** unsigned gives quotient = all ones, remainder = a. Signed gives the sign-corrected result of the same iteration. `div_zero` is still set.
- **Cancel:** `cancel` high at any edge forces IDLE and deasserts `out_valid` next cycle. It has priority over accept, iteration and output handshake. A request presented together with `cancel` is not accepted.
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `busy` = 0, `div_zero` = 0, `quotient` = 0, `remainder` = 0. Counter = 0, state = IDLE.
- **Reset mid-operation:** asserting `rst` at any time aborts immediately (asynchronously). There is no output pulse.

## Timing
- Accept at edge E0 puts the block in BUSY. Iterations occur on E1…E_WIDTH. `out_valid` rises after E_WIDTH, so latency is WIDTH cycles from accept.
- `out_valid` stays high until the edge where `out_ready` = 1. `in_ready` rises in the following cycle, giving at least one idle cycle between results.
- With `out_ready` tied high, throughput is one divide per WIDTH+2 cycles.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- **`DIV_ZERO_FAST_EN` defined:** if the latched b == 0, the accept edge goes directly to DONE, so `out_valid` rises one cycle after accept. Outputs are `quotient` = all ones, `remainder` = a (raw input), `div_zero` = 1. This holds in both modes.
- **`DIV_ZERO_FAST_EN` undefined:** b == 0 runs the full WIDTH iterations, with results as described in Operation and `div_zero` = 1. The compare-bypass logic is not built.

## Test plan
- **Unsigned:** WIDTH=32, `sign`=0, a=100, b=7 → `out_valid` exactly 32 cycles after accept; `quotient`=14, `remainder`=2, `div_zero`=0.
- **Signed:** `sign`=1, a=0xFFFFFFF9 (−7), b=2 → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0.
- **Divide by zero:** a=0x1234, b=0 → with the macro, `out_valid` 1 cycle after accept, `quotient`=0xFFFFFFFF, `remainder`=0x1234, `div_zero`=1. Without the macro, the same values after 32 cycles.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` and change a/b/`sign` → outputs unchanged and `in_ready`=0. Raise `out_ready` → `in_ready`=1 next cycle.
- **Cancel:** assert `cancel` on iteration 10 → `out_valid` never rises and `in_ready`=1 next cycle. A new request 255/16 then gives `quotient`=15, `remainder`=15.
- **Reset:** pull `rst` low asynchronously mid-BUSY, between clock edges → all outputs take reset values immediately. WIDTH=8 regression, `sign`=1, a=0x81 (−127), b=0x03 → `quotient`=0xD6 (−42), `remainder`=0xFF.

Source files
------------

// File: rtl/div_iter_if.sv
// Operand/result handshake bundle for the iterative divider.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             busy;

  modport master (
    output in_valid, sign, a, b, cancel, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, busy
  );

  modport slave (
    input  in_valid, sign, a, b, cancel, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, busy
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider (signed/unsigned, MIPS truncating semantics), WIDTH iterations.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes on the accept edge.
module div_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             in_ready_q, out_valid_q, busy_q;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Operand magnitudes; only signed-mode negatives are negated.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (io.sign && io.a[WIDTH-1]) ? negate(io.a) : io.a;
  assign b_mag = (io.sign && io.b[WIDTH-1]) ? negate(io.b) : io.b;

  // One restoring step; the compare is WIDTH+1 bits wide so no magnitude overflows.
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign ge       = shifted >= {1'b0, dmag_q};
  assign rem_step = ge ? (shifted[WIDTH-1:0] - dmag_q) : shifted[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    if (io.cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dmag_d  = b_mag;
            q_neg_d = io.sign && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            r_neg_d = io.sign && io.a[WIDTH-1];
            zero_d  = (io.b == '0);
`ifdef DIV_ZERO_FAST_EN
            // Zero divisor bypasses the iterations entirely.
            if (io.b == '0) begin
              state_d     = S_DONE;
              quotient_d  = '1;
              remainder_d = io.a;
              div_zero_d  = 1'b1;
            end
`endif
          end
        end
        S_BUSY: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d     = S_DONE;
            quotient_d  = q_neg_q ? negate(quo_step) : quo_step;
            remainder_d = r_neg_q ? negate(rem_step) : rem_step;
            div_zero_d  = zero_q;
          end
        end
        S_DONE: begin
          if (io.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.busy      = busy_q;
  assign io.quotient  = quotient_q;
  assign io.remainder = remainder_q;
  assign io.div_zero  = div_zero_q;

endmodule
